multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-precision add/subtract controller that sits directly upstream of, and consumes the result of, the team's 32-bit combinational carry-lookahead adder.
- Accepts wide operands as a stream of 32-bit limbs, least-significant first, and drives each limb pair into the adder.
- Chains the adder carry between limbs across cycles and registers each sum limb onto a valid/ready output stream.
- Produces a final carry/no-borrow flag and a signed-overflow flag with the last limb.

Parameters:
- WORDS, 4, limbs per operand (legal 2..16); operand width = 32*WORDS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- In_Valid  in  1  input limb valid.
- In_Ready  out  1  input limb accepted when In_Valid & In_Ready.
- A_Word  in  32  operand A limb.
- B_Word  in  32  operand B limb.
- In_Sub  in  1  1 = A-B, 0 = A+B; sampled only on the first limb of an operation.
- Flush  in  1  synchronous abort of the operation in progress.
- Add_A  out  32  to adder A input.
- Add_B  out  32  to adder B input.
- Add_Cin  out  1  to adder carry-in.
- Add_Sum  in  32  from adder sum output.
- Add_Cout  in  1  from adder carry-out.
- Out_Valid  out  1  result limb valid.
- Out_Ready  in  1  downstream accepts result limb.
- Sum_Word  out  32  result limb.
- Out_Last  out  1  marks the most-significant result limb.
- Carry_Out  out  1  final carry (add) or no-borrow (sub); valid when Out_Valid & Out_Last, else 0.
- Overflow  out  1  two's-complement overflow of the full-width result; valid when Out_Valid & Out_Last, else 0.

Behaviour:
Reset (rst_n=0 at clock edge):
- Out_Valid, Out_Last, Carry_Out, Overflow = 0; Sum_Word = 0.
- Limb counter = 0, carry register = 0, op_sub register = 0, state = IDLE.

State machine:
- IDLE: counter = 0; next accepted limb is the first limb.
- BUSY: counter 1..WORDS-1.
- IDLE→BUSY on accept of the first limb.
- BUSY→IDLE on accept of limb WORDS-1; the counter wraps to 0.

Combinational adder drive (always driven, no enable):
- Add_A = A_Word.
- Add_B = eff_sub ? ~B_Word : B_Word.
- eff_sub = In_Sub in IDLE, op_sub register in BUSY.
- Add_Cin = In_Sub in IDLE, carry register in BUSY.

Handshake:
- In_Ready = !Out_Valid | Out_Ready; single output register, one limb per cycle sustained.
- On accept:
  - Sum_Word <= Add_Sum; Out_Valid <= 1.
  - carry register <= Add_Cout.
  - Out_Last <= (counter == WORDS-1).
  - If last: Carry_Out <= Add_Cout and Overflow <= (A_Word[31] == Add_B[31]) & (Add_Sum[31] != A_Word[31]); otherwise both <= 0.
  - In IDLE: op_sub <= In_Sub.
- Output acceptance:
  - Out_Valid & Out_Ready with no new accept → Out_Valid <= 0.
  - Simultaneous output accept and input accept → output register is overwritten with the new limb.
  - While Out_Valid & !Out_Ready, all outputs hold stable.

Latency and ordering:
- Latency input accept → Out_Valid is 1 cycle.
- Limb order is preserved.
- Carry never propagates between separate operations: every first limb uses Cin = In_Sub.

Flush:
- Flush=1 at a clock edge: counter, carry and state return to IDLE, and the input limb is not accepted that cycle (In_Ready is forced 0 while Flush=1).
- An already-registered output limb remains valid until accepted, but has Out_Last forced to 0 if it was not last.
- Reset has priority over Flush.

Other boundary conditions:
- In_Sub changing mid-operation is ignored.
- In_Valid low mid-operation stalls without losing the carry, for any number of cycles.
- Reset mid-operation discards the partial operation; the next accepted limb is a first limb.

Test Plan:
- WORDS=4, add A=all-ones (4 limbs 0xFFFFFFFF), B=1 (limbs 1,0,0,0), Out_Ready=1 → Sum limbs 0,0,0,0 on consecutive cycles; Out_Last only on the 4th; Carry_Out=1, Overflow=0.
- Sub A=5, B=7 (upper limbs 0) → limbs 0xFFFFFFFE, 0xFFFFFFFF ×3; Carry_Out=0 (borrow), Overflow=0; Add_Cin=1 on the first limb.
- Add with top limbs A=0x7FFFFFFF, B=0x00000001, lower limbs 0 → top limb 0x80000000, Overflow=1, Carry_Out=0.
- Backpressure: hold Out_Ready=0 for 3 cycles after the first limb of the test-1 operands → In_Ready=0, Sum_Word/Out_Valid stable for 3 cycles; final limbs and flags identical to test 1.
- Reset (rst_n=0 one cycle) after 2 limbs of a subtract, then a fresh add of 1+1 → all outputs 0 during reset; new first limb has Add_Cin=0, result limbs 2,0,0,0, Carry_Out=0.
- Back-to-back: add all-ones+1 immediately followed by 0+0, Out_Ready=1 → 8 result limbs in 8 cycles; second operation limbs all 0 with Carry_Out=0 (no carry leakage); Flush after limb 1 of a third operation → next limb restarts at counter 0.

Source files
------------

// File: rtl/multiword_add_sequencer_if.sv
// Limb-stream, adder-drive and result-stream signals of the multi-word add/sub sequencer.
// The sequencer takes the slave side; the environment (stimulus, adder, sink) takes the master side.
interface multiword_add_sequencer_if;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] A_Word;
   logic [31:0] B_Word;
   logic        In_Sub;
   logic        Flush;
   logic [31:0] Add_A;
   logic [31:0] Add_B;
   logic        Add_Cin;
   logic [31:0] Add_Sum;
   logic        Add_Cout;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [31:0] Sum_Word;
   logic        Out_Last;
   logic        Carry_Out;
   logic        Overflow;

   modport slave (
      input  In_Valid, A_Word, B_Word, In_Sub, Flush, Add_Sum, Add_Cout, Out_Ready,
      output In_Ready, Add_A, Add_B, Add_Cin, Out_Valid, Sum_Word, Out_Last, Carry_Out, Overflow
   );

   modport master (
      output In_Valid, A_Word, B_Word, In_Sub, Flush, Add_Sum, Add_Cout, Out_Ready,
      input  In_Ready, Add_A, Add_B, Add_Cin, Out_Valid, Sum_Word, Out_Last, Carry_Out, Overflow
   );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams 32-bit limbs LS-first through an external
// combinational adder, chaining the carry across cycles and registering each sum limb.
module multiword_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   multiword_add_sequencer_if.slave    bus
);

   localparam int              CW       = (WORDS > 2) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0]   LAST_IDX = CW'(WORDS - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic          carry_reg, carry_next;
   logic          op_sub_reg, op_sub_next;
   logic [31:0]   sum_reg, sum_next;
   logic          valid_reg, valid_next;
   logic          last_reg, last_next;
   logic          cout_reg, cout_next;
   logic          ovf_reg, ovf_next;

   logic          in_ready;
   logic          accept;
   logic          eff_sub;
   logic [31:0]   add_b;
   logic          is_last;

   // Flush blocks acceptance so a flushed limb never starts a new operation.
   assign in_ready = (!valid_reg || bus.Out_Ready) && !bus.Flush;
   assign accept   = bus.In_Valid && in_ready;
   assign is_last  = (count_reg == LAST_IDX);

   // First limb takes its mode straight from In_Sub so no carry leaks between operations.
   assign eff_sub  = (state_reg == IDLE) ? bus.In_Sub : op_sub_reg;
   assign add_b    = eff_sub ? ~bus.B_Word : bus.B_Word;

   assign bus.Add_A     = bus.A_Word;
   assign bus.Add_B     = add_b;
   assign bus.Add_Cin   = (state_reg == IDLE) ? bus.In_Sub : carry_reg;
   assign bus.In_Ready  = in_ready;
   assign bus.Out_Valid = valid_reg;
   assign bus.Sum_Word  = sum_reg;
   assign bus.Out_Last  = valid_reg && last_reg;
   assign bus.Carry_Out = valid_reg && last_reg && cout_reg;
   assign bus.Overflow  = valid_reg && last_reg && ovf_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         carry_reg  <= 1'b0;
         op_sub_reg <= 1'b0;
         sum_reg    <= '0;
         valid_reg  <= 1'b0;
         last_reg   <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         carry_reg  <= carry_next;
         op_sub_reg <= op_sub_next;
         sum_reg    <= sum_next;
         valid_reg  <= valid_next;
         last_reg   <= last_next;
         cout_reg   <= cout_next;
         ovf_reg    <= ovf_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      carry_next  = carry_reg;
      op_sub_next = op_sub_reg;
      sum_next    = sum_reg;
      valid_next  = valid_reg;
      last_next   = last_reg;
      cout_next   = cout_reg;
      ovf_next    = ovf_reg;

      if (valid_reg && bus.Out_Ready) begin
         valid_next = 1'b0;
      end

      // A new accept overwrites the output register, including on a same-cycle drain.
      if (accept) begin
         sum_next   = bus.Add_Sum;
         valid_next = 1'b1;
         carry_next = bus.Add_Cout;
         last_next  = is_last;
         cout_next  = is_last && bus.Add_Cout;
         ovf_next   = is_last && (bus.A_Word[31] == add_b[31]) && (bus.Add_Sum[31] != bus.A_Word[31]);
         if (state_reg == IDLE) begin
            op_sub_next = bus.In_Sub;
         end
         if (is_last) begin
            state_next = IDLE;
            count_next = '0;
         end else begin
            state_next = BUSY;
            count_next = count_reg + 1'b1;
         end
      end

      // A registered limb from the flushed operation stays valid; it is already non-last.
      if (bus.Flush) begin
         state_next = IDLE;
         count_next = '0;
         carry_next = 1'b0;
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomized self-checking bench for multiword_add_sequencer against a wide-integer model.
module tb_multiword_add_sequencer;

   localparam int W = 4;
   localparam int N = 32 * W;

   typedef struct packed {
      logic [31:0] sum;
      logic        last;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   multiword_add_sequencer_if ifc ();

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_mode = 0;
   int   hold_cnt = 0;
   int   op_id = 0;

   multiword_add_sequencer #(.WORDS(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   // The team's 32-bit carry-lookahead adder, modelled behaviourally.
   assign {ifc.Add_Cout, ifc.Add_Sum} = {1'b0, ifc.Add_A} + {1'b0, ifc.Add_B} + {32'd0, ifc.Add_Cin};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full-width reference: unsigned result and carry/no-borrow, signed overflow via sign extension.
   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        output logic [N-1:0] res, output logic cout, output logic ovf);
      logic signed [N:0] sr;
      if (sub) begin
         res  = a - b;
         cout = (a >= b);
         sr   = $signed({a[N-1], a}) - $signed({b[N-1], b});
      end else begin
         {cout, res} = {1'b0, a} + {1'b0, b};
         sr   = $signed({a[N-1], a}) + $signed({b[N-1], b});
      end
      ovf = (sr[N] != sr[N-1]);
   endtask

   function automatic logic [N-1:0] rand_opnd();
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < W; i++) begin
         case ($urandom_range(0, 3))
            0:       v[32*i +: 32] = 32'h0;
            1:       v[32*i +: 32] = 32'hFFFF_FFFF;
            2:       v[32*i +: 32] = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v[32*i +: 32] = $urandom;
         endcase
      end
      return v;
   endfunction

   // Called just after a falling edge; returns just after a falling edge with In_Valid low.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input int n, input int gap_max, input int hold, output int stalls);
      logic [N-1:0] res;
      logic         cout, ovf;
      exp_t         e;
      int           wait_n;
      model(a, b, sub, res, cout, ovf);
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         ifc.In_Valid = 1'b1;
         ifc.A_Word   = a[32*i +: 32];
         ifc.B_Word   = b[32*i +: 32];
         ifc.In_Sub   = (i == 0) ? sub : 1'($urandom_range(0, 1));
         #1;
         if (i == 0) check("add_cin_first", {31'd0, ifc.Add_Cin}, {31'd0, sub});
         check("add_b", ifc.Add_B, sub ? ~b[32*i +: 32] : b[32*i +: 32]);
         wait_n = 0;
         while (!ifc.In_Ready && wait_n < 200) begin
            @(negedge clk);
            #1;
            wait_n++;
         end
         stalls += wait_n;
         if (wait_n >= 200) begin
            check("in_ready_timeout", 32'd0, 32'd1);
         end else begin
            e.sum  = res[32*i +: 32];
            e.last = (i == W - 1);
            e.cout = e.last && cout;
            e.ovf  = e.last && ovf;
            exp_q.push_back(e);
            if (i == 0 && hold > 0) hold_cnt = hold;
         end
         @(negedge clk);
         ifc.In_Valid = 1'b0;
      end
      $display("op %0d: sub=%0d limbs=%0d/%0d stalls=%0d a=%h b=%h", op_id, sub, n, W, stalls, a, b);
      op_id++;
   endtask

   // Output sink and scoreboard; compares the head entry every cycle it is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (hold_cnt > 0) begin
            ifc.Out_Ready = 1'b0;
            hold_cnt--;
         end else begin
            ifc.Out_Ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         #2;
         if (rst_n) begin
            check("in_ready", {31'd0, ifc.In_Ready},
                  {31'd0, (!ifc.Out_Valid || ifc.Out_Ready) && !ifc.Flush});
            if (ifc.Out_Valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out_valid", 32'd1, 32'd0);
               end else begin
                  e = exp_q[0];
                  check("sum_word", ifc.Sum_Word, e.sum);
                  check("out_last", {31'd0, ifc.Out_Last}, {31'd0, e.last});
                  check("carry_out", {31'd0, ifc.Carry_Out}, {31'd0, e.cout});
                  check("overflow", {31'd0, ifc.Overflow}, {31'd0, e.ovf});
                  if (ifc.Out_Ready) void'(exp_q.pop_front());
               end
            end else begin
               check("idle_flags", {30'd0, ifc.Carry_Out, ifc.Overflow}, 32'd0);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] a, b;
      int           st, st2, t;
      rst_n        = 1'b0;
      ifc.In_Valid = 1'b0;
      ifc.A_Word   = '0;
      ifc.B_Word   = '0;
      ifc.In_Sub   = 1'b0;
      ifc.Flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, ifc.Out_Valid}, 32'd0);
      check("rst_sum_word", ifc.Sum_Word, 32'd0);
      check("rst_flags", {29'd0, ifc.Out_Last, ifc.Carry_Out, ifc.Overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All-ones + 1: zero limbs, carry out, no overflow, full throughput.
      a = {N{1'b1}};
      b = N'(1);
      run_op(a, b, 1'b0, W, 0, 0, st);
      check("t1_stalls", st, 0);

      // 5 - 7: borrow, Cin=1 on first limb.
      run_op(N'(5), N'(7), 1'b1, W, 0, 0, st);

      // Signed overflow into the top limb.
      a = {32'h7FFF_FFFF, {(N-32){1'b0}}};
      b = {32'h0000_0001, {(N-32){1'b0}}};
      run_op(a, b, 1'b0, W, 0, 0, st);

      // Backpressure for three cycles after the first limb.
      a = {N{1'b1}};
      b = N'(1);
      run_op(a, b, 1'b0, W, 0, 3, st);
      check("bp_stalls", st, 3);

      // Reset part-way through a subtract, then 1+1.
      run_op(rand_opnd(), rand_opnd(), 1'b1, 2, 0, 0, st);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      check("midrst_out_valid", {31'd0, ifc.Out_Valid}, 32'd0);
      check("midrst_sum_word", ifc.Sum_Word, 32'd0);
      check("midrst_flags", {29'd0, ifc.Out_Last, ifc.Carry_Out, ifc.Overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(N'(1), N'(1), 1'b0, W, 0, 0, st);

      // Back-to-back operations, no carry leakage, then flush after one limb.
      run_op({N{1'b1}}, N'(1), 1'b0, W, 0, 0, st);
      run_op(N'(0), N'(0), 1'b0, W, 0, 0, st2);
      check("b2b_stalls", st + st2, 0);
      run_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 1, 0, 0, st);
      ifc.In_Valid = 1'b1;
      ifc.A_Word   = $urandom;
      ifc.B_Word   = $urandom;
      ifc.Flush    = 1'b1;
      #1;
      check("flush_in_ready", {31'd0, ifc.In_Ready}, 32'd0);
      @(negedge clk);
      ifc.Flush    = 1'b0;
      ifc.In_Valid = 1'b0;
      run_op(rand_opnd(), rand_opnd(), 1'b1, W, 0, 0, st);

      // Randomized operations with input gaps and random backpressure.
      for (int k = 0; k < 40; k++) begin
         ready_mode = $urandom_range(0, 1);
         run_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), W, 3, 0, st);
      end

      ready_mode = 0;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
